// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared arbiter state, master ids and bus op encoding
//
// Purpose: types and constants shared by the data bus arbiter and the control unit.
// Contents: arb_state_t (ARB_IDLE/ARB_BUSY/ARB_DONE), MST_CPU/MST_AUX master ids,
//           bus_op_t (BUS_OP_NONE/READ/WRITE), req_to_op() strobe-pair decoder.
package cpu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_AUX = 1'b1;

    typedef enum logic [1:0] {
        BUS_OP_NONE  = 2'd0,
        BUS_OP_READ  = 2'd1,
        BUS_OP_WRITE = 2'd2
    } bus_op_t;

    // A master raising read and write together is serviced as a write.
    function automatic bus_op_t req_to_op(input logic rd, input logic wr);
        if (wr) begin
            return BUS_OP_WRITE;
        end else if (rd) begin
            return BUS_OP_READ;
        end
        return BUS_OP_NONE;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - counts wait cycles of one bus access and flags expiry
//
// Purpose: counts cycles while enable is high; expired marks the LIMIT-th enabled cycle.
// Ports:
//   clk     in  clock, rising edge
//   reset   in  asynchronous active-high reset
//   enable  in  access in progress, count this cycle
//   clear   in  return the count to zero (has priority over enable)
//   expired out high during the LIMIT-th enabled cycle; never high when LIMIT = 0
module bus_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    generate
        if (LIMIT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(LIMIT + 1);
            logic [CW-1:0] count;

            // Saturates at LIMIT, so the count can never wrap back into range.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable && (count != CW'(LIMIT))) begin
                    count <= count + 1'b1;
                end
            end

            // The count holds the number of cycles already spent, so the cycle
            // in which it equals LIMIT-1 is the last one allowed.
            assign expired = enable && (count == CW'(LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master arbiter for the synchronous-read data bus
//
// Purpose: shares the slave bus between the CPU data port (m0) and a secondary master (m1),
//          sequencing each access IDLE -> BUSY -> DONE with wait-state and timeout support.
// Ports:
//   clk, reset                        clock / asynchronous active-high reset
//   mX_read, mX_write, mX_addr, mX_wdata  requests, held until mX_ack
//   mX_rdata, mX_ack, mX_err          one-cycle completion with read data / timeout flag
//   bus_read, bus_write, bus_addr, bus_wdata  registered slave strobes and payload
//   bus_rdata, bus_ready              slave read data and completion
//   cpu_stall                         CPU access outstanding and not completing this cycle
import cpu_pkg::*;

module data_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              cpu_stall
);

    arb_state_t        state;
    logic              grant;
    logic              last_grant;
    logic              m0_req;
    logic              m1_req;
    logic              winner;
    bus_op_t           win_op;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [DATA_W-1:0] cap_rdata;
    logic              expired;

    assign m0_req    = m0_read | m0_write;
    assign m1_req    = m1_read | m1_write;
    assign cpu_stall = m0_req & ~m0_ack;

    // Contention goes to the master that did not own the previous access when
    // fair; otherwise the CPU always wins.
    always_comb begin
        winner = MST_CPU;
        if (m0_req && m1_req) begin
            if ((FAIR != 0) && (last_grant == MST_CPU)) begin
                winner = MST_AUX;
            end
        end else if (m1_req) begin
            winner = MST_AUX;
        end
    end

    always_comb begin
        win_op    = req_to_op(m0_read, m0_write);
        win_addr  = m0_addr;
        win_wdata = m0_wdata;
        if (winner == MST_AUX) begin
            win_op    = req_to_op(m1_read, m1_write);
            win_addr  = m1_addr;
            win_wdata = m1_wdata;
        end
    end

    // Writes return zero so rdata is only ever slave data for a completed read.
    assign cap_rdata = (bus_ready && bus_read) ? bus_rdata : '0;

    bus_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (state == ARB_BUSY),
        .clear   (state != ARB_BUSY),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            grant      <= MST_CPU;
            last_grant <= MST_AUX;
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (m0_req || m1_req) begin
                        bus_read   <= (win_op == BUS_OP_READ);
                        bus_write  <= (win_op == BUS_OP_WRITE);
                        bus_addr   <= win_addr;
                        bus_wdata  <= win_wdata;
                        grant      <= winner;
                        last_grant <= winner;
                        state      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // A ready slave completes normally even in the expiry cycle.
                    if (bus_ready || expired) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        m0_ack    <= (grant == MST_CPU);
                        m1_ack    <= (grant == MST_AUX);
                        m0_err    <= (grant == MST_CPU) && !bus_ready;
                        m1_err    <= (grant == MST_AUX) && !bus_ready;
                        m0_rdata  <= (grant == MST_CPU) ? cap_rdata : '0;
                        m1_rdata  <= (grant == MST_AUX) ? cap_rdata : '0;
                        state     <= ARB_DONE;
                    end
                end
                ARB_DONE: begin
                    m0_ack   <= 1'b0;
                    m0_err   <= 1'b0;
                    m0_rdata <= '0;
                    m1_ack   <= 1'b0;
                    m1_err   <= 1'b0;
                    m1_rdata <= '0;
                    state    <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - scoreboard bench for data_bus_arbiter
module tb_data_bus_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        bus_read, bus_write, cpu_stall;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ready = 1'b0;

    logic        p_m0_read, p_m0_write, p_m1_read, p_m1_write;
    logic [31:0] p_m0_addr, p_m0_wdata, p_m1_addr, p_m1_wdata;
    logic [31:0] p_m0_rdata, p_m1_rdata, p_bus_addr, p_bus_wdata;
    logic        p_m0_ack, p_m0_err, p_m1_ack, p_m1_err;
    logic        p_bus_read, p_bus_write, p_cpu_stall;

    data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .cpu_stall(cpu_stall)
    );

    data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(0), .TIMEOUT(TO)) dut_p (
        .clk(clk), .reset(reset),
        .m0_read(p_m0_read), .m0_write(p_m0_write), .m0_addr(p_m0_addr), .m0_wdata(p_m0_wdata),
        .m0_rdata(p_m0_rdata), .m0_ack(p_m0_ack), .m0_err(p_m0_err),
        .m1_read(p_m1_read), .m1_write(p_m1_write), .m1_addr(p_m1_addr), .m1_wdata(p_m1_wdata),
        .m1_rdata(p_m1_rdata), .m1_ack(p_m1_ack), .m1_err(p_m1_err),
        .bus_read(p_bus_read), .bus_write(p_bus_write), .bus_addr(p_bus_addr), .bus_wdata(p_bus_wdata),
        .bus_rdata(32'hCAFEF00D), .bus_ready(1'b1), .cpu_stall(p_cpu_stall)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endfunction

    // Slave memory contents as seen through bus_rdata.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    typedef struct { int m; int cyc; logic [31:0] rdata; logic err; } ack_t;
    typedef struct { int cyc; logic [31:0] addr; logic wr; logic [31:0] wdata; } bus_t;

    ack_t ack_q[$];
    bus_t bus_q[$];
    int   wait_q[$];
    bit   m0_ack_at[int];
    int   lg = 1;

    // Per-master transaction lists for one batch.
    int          t_n[2];
    int          t_op[2][8];
    logic [31:0] t_addr[2][8];
    logic [31:0] t_wdata[2][8];
    int          t_gap[2][8];
    int          t_wait[2][8];

    function automatic void add_txn(input int m, input int op, input logic [31:0] a,
                                    input logic [31:0] d, input int gap, input int w);
        t_op[m][t_n[m]]    = op;
        t_addr[m][t_n[m]]  = a;
        t_wdata[m][t_n[m]] = d;
        t_gap[m][t_n[m]]   = gap;
        t_wait[m][t_n[m]]  = w;
        t_n[m]++;
    endfunction

    task automatic set_req(input int m, input int op, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_read = op[0]; m0_write = op[1]; m0_addr = a; m0_wdata = d;
        end else begin
            m1_read = op[0]; m1_write = op[1]; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic drive_master(input int m);
        for (int i = 0; i < t_n[m]; i++) begin
            bit got;
            repeat (t_gap[m][i]) begin @(posedge clk); #1; end
            set_req(m, t_op[m][i], t_addr[m][i], t_wdata[m][i]);
            got = 0;
            for (int k = 0; k < 300 && !got; k++) begin
                @(negedge clk);
                got = (m == 0) ? m0_ack : m1_ack;
            end
            if (!got) begin
                bound_fail(m == 0 ? "m0_ack_wait" : "m1_ack_wait");
                set_req(m, 0, 0, 0);
                return;
            end
            @(posedge clk); #1;
            set_req(m, 0, 0, 0);
        end
    endtask

    // Transaction-level model: the arbiter is idle at cycle t, grants whichever
    // pending request is visible (round-robin on contention) and is idle again
    // the cycle after the ack.
    task automatic run_batch();
        int t;
        int idx[2];
        int rdy[2];
        t = cyc;
        idx[0] = 0; idx[1] = 0;
        rdy[0] = 0; rdy[1] = 0;
        for (int m = 0; m < 2; m++) if (t_n[m] > 0) rdy[m] = t + t_gap[m][0];
        while (idx[0] < t_n[0] || idx[1] < t_n[1]) begin
            bit c0, c1;
            c0 = (idx[0] < t_n[0]) && (rdy[0] <= t);
            c1 = (idx[1] < t_n[1]) && (rdy[1] <= t);
            if (!c0 && !c1) begin
                int nt;
                nt = 1 << 30;
                if (idx[0] < t_n[0] && rdy[0] < nt) nt = rdy[0];
                if (idx[1] < t_n[1] && rdy[1] < nt) nt = rdy[1];
                t = nt;
            end else begin
                int m, w, busy, ackc;
                bit wr;
                if (c0 && c1) m = (lg == 0) ? 1 : 0;
                else          m = c0 ? 0 : 1;
                lg   = m;
                w    = t_wait[m][idx[m]];
                busy = (w < TO) ? w + 1 : TO;
                ackc = t + 1 + busy;
                wr   = (t_op[m][idx[m]] >= 2);
                bus_q.push_back('{t + 1, t_addr[m][idx[m]], wr, t_wdata[m][idx[m]]});
                wait_q.push_back(w);
                ack_q.push_back('{m, ackc, (w >= TO || wr) ? 32'h0 : mem(t_addr[m][idx[m]]), (w >= TO)});
                if (m == 0) m0_ack_at[ackc] = 1;
                idx[m]++;
                if (idx[m] < t_n[m]) rdy[m] = ackc + 1 + t_gap[m][idx[m]];
                t = ackc + 1;
            end
        end
        fork
            drive_master(0);
            drive_master(1);
        join
        t_n[0] = 0;
        t_n[1] = 0;
    endtask

    // Slave: waits the scheduled number of cycles, then presents ready with data.
    int s_w = 0, s_cnt = 0;
    bit s_act = 0;
    always @(negedge clk) begin
        if (bus_read | bus_write) begin
            if (!s_act) begin
                s_act = 1;
                s_cnt = 0;
                s_w   = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            end
            bus_ready = (s_cnt == s_w);
            bus_rdata = bus_ready ? mem(bus_addr) : $urandom;
            s_cnt++;
        end else begin
            s_act     = 0;
            bus_ready = 1'b0;
            bus_rdata = $urandom;
        end
    end

    // Bus monitor: checks start cycle and payload of every access and that it is held.
    bit   prev_strobe = 0;
    bus_t cur;
    always @(negedge clk) begin
        bit s;
        s = bus_read | bus_write;
        if (bus_read && bus_write) bound_fail("bus_both_strobes");
        if (s && !prev_strobe) begin
            if (bus_q.size() == 0) begin
                bound_fail("bus_unexpected_access");
            end else begin
                cur = bus_q.pop_front();
                chk("bus_start_cycle", cyc, cur.cyc);
                chk("bus_addr", bus_addr, cur.addr);
                chk("bus_write", bus_write, cur.wr);
                chk("bus_read", bus_read, !cur.wr);
                if (cur.wr) chk("bus_wdata", bus_wdata, cur.wdata);
            end
        end else if (s) begin
            chk("bus_hold_addr", bus_addr, cur.addr);
            chk("bus_hold_write", bus_write, cur.wr);
            if (cur.wr) chk("bus_hold_wdata", bus_wdata, cur.wdata);
        end
        prev_strobe = s;
    end

    // Completion monitor: pops the scoreboard on every ack, checks stall every cycle.
    always @(negedge clk) begin
        chk("cpu_stall", cpu_stall, (m0_read | m0_write) && !m0_ack_at.exists(cyc));
        if (m0_ack && m1_ack) bound_fail("double_ack");
        for (int m = 0; m < 2; m++) begin
            logic        a, e;
            logic [31:0] r;
            a = (m == 0) ? m0_ack : m1_ack;
            e = (m == 0) ? m0_err : m1_err;
            r = (m == 0) ? m0_rdata : m1_rdata;
            if (a) begin
                if (ack_q.size() == 0) begin
                    bound_fail("unexpected_ack");
                end else begin
                    ack_t x;
                    x = ack_q.pop_front();
                    chk("ack_master", m, x.m);
                    chk("ack_cycle", cyc, x.cyc);
                    chk("ack_rdata", r, x.rdata);
                    chk("ack_err", e, x.err);
                end
            end else begin
                chk(m == 0 ? "m0_quiet" : "m1_quiet", {e, r}, 33'h0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        p_m0_read = 0; p_m0_write = 0; p_m0_addr = 0; p_m0_wdata = 0;
        p_m1_read = 0; p_m1_write = 0; p_m1_addr = 0; p_m1_wdata = 0;
        t_n[0] = 0; t_n[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus", {bus_read, bus_write, bus_addr, bus_wdata}, 66'h0);
        chk("rst_m0", {m0_ack, m0_err, m0_rdata}, 34'h0);
        chk("rst_m1", {m1_ack, m1_err, m1_rdata}, 34'h0);
        reset = 1'b0;

        // Contention right after reset (CPU first, then aux), then the zero-wait CPU read.
        add_txn(0, 2, 32'h40, 32'hA1A1A1A1, 0, 0);
        add_txn(0, 1, 32'h100, 32'h0, 0, 0);
        add_txn(1, 1, 32'h300, 32'h0, 0, 1);
        run_batch();

        // Wait states on an aux write, then an aux dual-strobe request.
        add_txn(1, 2, 32'h80, 32'h12345678, 0, 3);
        add_txn(1, 3, 32'h84, 32'h0BADF00D, 1, 0);
        run_batch();

        // Timeout, ready in the expiry cycle, long timeout, normal access after.
        add_txn(0, 1, 32'h200, 32'h0, 0, 8);
        add_txn(0, 1, 32'h204, 32'h0, 0, 7);
        add_txn(0, 2, 32'h208, 32'h55, 2, 30);
        add_txn(1, 1, 32'h20C, 32'h0, 3, 0);
        run_batch();

        // Reset during the second BUSY cycle abandons the access.
        bus_q.push_back('{cyc + 1, 32'h400, 1'b0, 32'h0});
        wait_q.push_back(100);
        set_req(0, 1, 32'h400, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_bus_read", bus_read, 1'b1);
        reset = 1'b1;
        set_req(0, 0, 0, 0);
        #1;
        chk("async_rst_bus", {bus_read, bus_write, bus_addr}, 34'h0);
        chk("async_rst_ack", {m0_ack, m1_ack, cpu_stall}, 3'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        lg = 1;
        add_txn(0, 1, 32'h404, 32'h0, 0, 0);
        run_batch();

        // Randomized batches, waits spanning zero-wait through timeout.
        for (int b = 0; b < 25; b++) begin
            int n0, n1;
            n0 = $urandom_range(0, 4);
            n1 = $urandom_range((n0 == 0) ? 1 : 0, 4);
            for (int i = 0; i < n0 + n1; i++) begin
                int w;
                w = ($urandom_range(0, 5) == 0) ? $urandom_range(7, 12) : $urandom_range(0, 3);
                add_txn((i < n0) ? 0 : 1, $urandom_range(1, 3), $urandom, $urandom,
                        $urandom_range(0, 3), w);
            end
            run_batch();
        end

        // Fixed-priority instance: CPU keeps winning while it re-requests.
        p_m0_write = 1; p_m0_addr = 32'h10; p_m0_wdata = 32'h1;
        p_m1_read  = 1; p_m1_addr = 32'h20;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("p_m0_ack", p_m0_ack, (c == 2 || c == 5));
            chk("p_m1_ack", p_m1_ack, (c == 8));
            if (c == 8) chk("p_m1_rdata", p_m1_rdata, 32'hCAFEF00D);
            @(posedge clk); #1;
            if (c == 2) p_m0_addr = 32'h14;
            if (c == 5) p_m0_write = 0;
            if (c == 8) p_m1_read = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("ack_q_left", ack_q.size(), 0);
        chk("bus_q_left", bus_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single synchronous-read data bus between two requesters: the CPU data port (m0, driven from the control unit's bus read/write signals) and a secondary master (m1, debug/DMA).
- Sequences each access through a small FSM, tolerates slave wait states, and aborts hung accesses with a timeout.
- Produces the CPU stall signal covering any outstanding CPU access, replacing the fixed one-cycle load stall.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- FAIR, 1, 1 = round-robin between m0/m1 on contention; 0 = m0 fixed priority.
- TIMEOUT, 16, max BUSY cycles waiting for bus_ready; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_read / m0_write  in  1 each  CPU request; held until m0_ack.
- m0_addr  in  ADDR_W  CPU address, stable while requesting.
- m0_wdata  in  DATA_W  CPU write data, stable while requesting.
- m0_rdata  out  DATA_W  read data, valid only while m0_ack=1.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  timeout flag, qualified by m0_ack.
- m1_read, m1_write, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err  same as m0, for the secondary master.
- bus_read / bus_write  out  1 each  slave strobes, registered.
- bus_addr  out  ADDR_W  slave address, registered.
- bus_wdata  out  DATA_W  slave write data, registered.
- bus_rdata  in  DATA_W  slave read data, sampled with bus_ready.
- bus_ready  in  1  slave completion; may be high in the first BUSY cycle (zero wait).
- cpu_stall  out  1  combinational: (m0_read|m0_write) & ~m0_ack.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All bus_*, mX_ack, mX_err, mX_rdata = 0; timeout counter = 0.
  - last_grant = m1, so m0 wins the first contention.
  - Reset during BUSY abandons the access with no ack to either master.
- States: IDLE, BUSY, DONE.
- IDLE, at the clock edge:
  - If any request is present, pick the winner and register its addr/wdata/op into bus_*; go to BUSY; record grant.
  - FAIR=1: on contention, grant the master not in last_grant. FAIR=0: m0 always wins contention.
  - read & write both high on one master: treated as a write; the read is ignored.
- BUSY:
  - bus_read/bus_write held high; timeout counter increments each cycle.
  - On an edge with bus_ready=1: capture bus_rdata (writes capture 0), drop bus_*, go to DONE.
  - Else, if TIMEOUT!=0 and the counter reaches TIMEOUT: drop bus_*, set err, rdata=0, go to DONE.
  - bus_ready takes precedence over timeout in the same cycle.
- DONE:
  - Granted master's ack=1 for exactly one cycle, with rdata/err.
  - Counter clears; go to IDLE.
  - The non-granted master's outputs stay 0.
- Latency:
  - Request visible in cycle N gives bus strobe in N+1.
  - Zero-wait access: ack in N+2, IDLE in N+3. Throughput is one access per 3 cycles.
  - k wait cycles add k.
- Requester contract: drop or change the request in the cycle after ack. The arbiter never re-grants in DONE.
- Non-granted requester simply waits; its request is not lost.
- cpu_stall is high from the first request cycle up to, but not including, the ack cycle.
- Counter width: clog2(TIMEOUT+1); no wrap, since it saturates at the exit condition.

Decomposition:
- Shared package (cpu_pkg):
  - state enum (ARB_IDLE, ARB_BUSY, ARB_DONE).
  - master-id constants (MST_CPU=0, MST_AUX=1).
  - Bus op encoding reused with the control unit (BUS_OP_NONE/READ/WRITE).
- One sub-module: bus_timeout_counter.
  - Inputs: enable, clear, limit parameter.
  - Output: expired.
- Grant logic and FSM stay in data_bus_arbiter.

Test Plan:
- Zero-wait CPU read (all cases: request in cycle N):
  - Stimulus: m0_read at addr 0x100, bus_ready tied 1, bus_rdata=0xDEADBEEF.
  - Response: bus_read=1 with bus_addr=0x100 in N+1; m0_ack=1, m0_rdata=0xDEADBEEF in N+2; cpu_stall=1 in N..N+1, 0 in N+2.
- Contention:
  - Stimulus: FAIR=1; m0_write and m1_read both rise in the first cycle after reset.
  - Response: m0 is served first, then m1. On a second simultaneous pair, m1 wins. With FAIR=0, m0 always wins.
- Wait states:
  - Stimulus: bus_ready low for 3 BUSY cycles, then high; m1_write wdata=0x12345678.
  - Response: bus_wdata=0x12345678 is held for 4 cycles; m1_ack lands 1 cycle after bus_ready; m1_err=0.
- Timeout:
  - Stimulus: TIMEOUT=8, bus_ready never asserted.
  - Response: bus_read high N+1..N+8; m0_ack=1, m0_err=1, m0_rdata=0 in N+9; the next request is served normally.
- Reset mid-access:
  - Stimulus: assert reset in the second BUSY cycle.
  - Response: bus_read, ack and cpu_stall logic outputs go to 0 asynchronously; no ack is issued. After release, a new m0 read completes with normal latency.
- Dual-strobe request:
  - Stimulus: m1_read=m1_write=1.
  - Response: bus_write=1, bus_read=0; m1_ack in N+2.
